// File: rtl/serial_adder.sv
// Bit-serial adder: LSB-first ripple through a single full adder,
// one result every WIDTH+2 cycles.
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        ADD,
        DONE
    } state_t;

    state_t state, state_nx;

    logic [WIDTH-1:0] areg, breg, sreg;
    logic [CW-1:0]    cnt;
    logic             carry;
    logic             hs, hc, fbit, fcarry;
    logic             last;

    // two half-adder stages plus an OR
    assign hs     = areg[0] ^ breg[0];
    assign hc     = areg[0] & breg[0];
    assign fbit   = hs ^ carry;
    assign fcarry = hc | (hs & carry);
    assign last   = (cnt == LAST);

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (start) state_nx = ADD;
            ADD:     if (last) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_nx;
            busy  <= (state_nx != IDLE);
            done  <= (state_nx == DONE);
        end
    end

    // sum/cout are a separate result register so they stay stable
    // between results, including while the next addition runs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            areg  <= '0;
            breg  <= '0;
            sreg  <= '0;
            cnt   <= '0;
            carry <= 1'b0;
            sum   <= '0;
            cout  <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        areg  <= a;
                        breg  <= b;
                        carry <= 1'b0;
                        cnt   <= '0;
                    end
                end
                ADD: begin
                    areg  <= areg >> 1;
                    breg  <= breg >> 1;
                    sreg  <= {fbit, sreg[WIDTH-1:1]};
                    carry <= fcarry;
                    cnt   <= cnt + CW'(1);
                    if (last) begin
                        sum  <= {fbit, sreg[WIDTH-1:1]};
                        cout <= fcarry;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// Directed and back-to-back checks for serial_adder at WIDTH=8.
// Outputs are sampled on the falling clock edge.
module tb_serial_adder;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [7:0] a = '0;
    logic [7:0] b = '0;
    logic       busy, done, cout;
    logic [7:0] sum;

    int checks = 0;
    int failures = 0;

    serial_adder #(.WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .a(a), .b(b), .busy(busy), .done(done),
        .sum(sum), .cout(cout)
    );

    always #5 clk = ~clk;

    // one start pulse, then observe 20 falling edges
    task automatic run_op(
        input  logic [7:0] oa, input logic [7:0] ob, input bit inject,
        output logic [7:0] rs, output logic rc, output int lat,
        output int nbusy, output int ndone,
        output logic [7:0] rs_end, output logic rc_end);
        lat = -1; nbusy = 0; ndone = 0; rs = 'x; rc = 'x;
        @(negedge clk);
        a = oa; b = ob; start = 1'b1;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            if (n == 1) begin
                start = 1'b0; a = ~oa; b = oa ^ ob;
            end
            if (inject && n == 3) begin
                start = 1'b1; a = 8'h77; b = 8'h99;
            end
            if (inject && n == 4) start = 1'b0;
            if (busy) nbusy++;
            if (done) begin
                ndone++;
                if (lat < 0) begin
                    lat = n - 1; rs = sum; rc = cout;
                end
            end
        end
        rs_end = sum; rc_end = cout;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({busy, done, cout, sum} !== 11'h000) begin
            failures++;
            $display("FAIL reset_state busy=%b done=%b cout=%b sum=%h want 0", busy, done, cout, sum);
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_release done=%b busy=%b want 0 0", done, busy);
        end
    endtask

    task automatic test_add(input string nm, input logic [7:0] oa,
                            input logic [7:0] ob, input logic [7:0] es,
                            input logic ec);
        logic [7:0] rs, rse; logic rc, rce; int lat, nb, nd;
        run_op(oa, ob, 1'b0, rs, rc, lat, nb, nd, rse, rce);
        checks++;
        if ({rc, rs} !== {ec, es}) begin
            failures++;
            $display("FAIL %s result cout=%b sum=%h want cout=%b sum=%h", nm, rc, rs, ec, es);
        end
        checks++;
        if (lat !== 8) begin
            failures++;
            $display("FAIL %s latency got %0d want 8", nm, lat);
        end
        checks++;
        if (nb !== 9 || nd !== 1) begin
            failures++;
            $display("FAIL %s busy_cycles=%0d dones=%0d want 9 1", nm, nb, nd);
        end
        checks++;
        if ({rce, rse} !== {ec, es}) begin
            failures++;
            $display("FAIL %s hold cout=%b sum=%h want cout=%b sum=%h", nm, rce, rse, ec, es);
        end
    endtask

    task automatic test_ignore_start;
        logic [7:0] rs, rse; logic rc, rce; int lat, nb, nd;
        run_op(8'h3C, 8'h4B, 1'b1, rs, rc, lat, nb, nd, rse, rce);
        checks++;
        if ({rc, rs} !== 9'h087 || lat !== 8) begin
            failures++;
            $display("FAIL ignore_start cout=%b sum=%h lat=%0d want 0 87 8", rc, rs, lat);
        end
        checks++;
        if (nd !== 1 || nb !== 9) begin
            failures++;
            $display("FAIL ignore_start dones=%0d busy=%0d want 1 9", nd, nb);
        end
        checks++;
        if ({rce, rse} !== 9'h087) begin
            failures++;
            $display("FAIL ignore_start hold cout=%b sum=%h want 0 87", rce, rse);
        end
    endtask

    task automatic test_reset_abort;
        logic [7:0] rs, rse; logic rc, rce; int lat, nb, nd;
        int nd_ab;
        nd_ab = 0;
        @(negedge clk);
        a = 8'hFF; b = 8'hFF; start = 1'b1;
        for (int n = 1; n <= 4; n++) begin
            @(negedge clk);
            if (n == 1) start = 1'b0;
            if (done) nd_ab++;
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, done, cout, sum} !== 11'h000) begin
            failures++;
            $display("FAIL abort_reset busy=%b done=%b cout=%b sum=%h want 0", busy, done, cout, sum);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int n = 0; n < 12; n++) begin
            @(negedge clk);
            if (done || busy) nd_ab++;
        end
        checks++;
        if (nd_ab !== 0) begin
            failures++;
            $display("FAIL abort_no_done activity=%0d want 0", nd_ab);
        end
        run_op(8'h12, 8'h34, 1'b0, rs, rc, lat, nb, nd, rse, rce);
        checks++;
        if ({rc, rs} !== 9'h046 || lat !== 8 || nd !== 1) begin
            failures++;
            $display("FAIL abort_after cout=%b sum=%h lat=%0d dones=%0d want 0 46 8 1", rc, rs, lat, nd);
        end
    endtask

    task automatic test_back_to_back;
        logic [7:0] pa [256];
        logic [7:0] pb [256];
        logic [8:0] exp9;
        logic [7:0] last_sum;
        int idx, last_t, t, bad_res, bad_gap, bad_stab;
        idx = 0; last_t = -1; t = 0;
        bad_res = 0; bad_gap = 0; bad_stab = 0;
        last_sum = '0;
        for (int i = 0; i < 256; i++) begin
            pa[i] = 8'($urandom);
            pb[i] = 8'($urandom);
        end
        @(negedge clk);
        a = pa[0]; b = pb[0]; start = 1'b1;
        while (idx < 256 && t < 4000) begin
            @(negedge clk);
            t++;
            if (done) begin
                exp9 = {1'b0, pa[idx]} + {1'b0, pb[idx]};
                if ({cout, sum} !== exp9) bad_res++;
                if (last_t >= 0 && t - last_t != 10) bad_gap++;
                last_t = t;
                last_sum = sum;
                idx++;
                if (idx < 256) begin
                    a = pa[idx]; b = pb[idx];
                end else begin
                    start = 1'b0;
                end
            end else if (last_t >= 0 && sum !== last_sum) begin
                bad_stab++;
            end
        end
        start = 1'b0;
        checks++;
        if (idx !== 256) begin
            failures++;
            $display("FAIL b2b_count results=%0d want 256 (timeout)", idx);
        end
        checks++;
        if (bad_res !== 0) begin
            failures++;
            $display("FAIL b2b_results wrong=%0d want 0", bad_res);
        end
        checks++;
        if (bad_gap !== 0) begin
            failures++;
            $display("FAIL b2b_spacing bad_gaps=%0d want 0", bad_gap);
        end
        checks++;
        if (bad_stab !== 0) begin
            failures++;
            $display("FAIL b2b_stable changes=%0d want 0", bad_stab);
        end
        repeat (12) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_add("zero", 8'h00, 8'h00, 8'h00, 1'b0);
        test_add("ff_01", 8'hFF, 8'h01, 8'h00, 1'b1);
        test_add("ff_ff", 8'hFF, 8'hFF, 8'hFE, 1'b1);
        test_add("a5_5a", 8'hA5, 8'h5A, 8'hFF, 1'b0);
        test_ignore_start();
        test_reset_abort();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/serial_adder.md
SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 Parameter: WIDTH, default 8, operand and sum width in bits; legal range 2..32.
REQ-002 Clocking: the block SHALL use one clock; reset SHALL be asynchronous and active-low.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 start  input  1  request to add a and b; sampled on rising clk.
REQ-006 a  input  WIDTH  operand A; sampled only on the accepting edge.
REQ-007 b  input  WIDTH  operand B; sampled only on the accepting edge.
REQ-008 busy  output  1  high while an addition is in progress (ADD or DONE state).
REQ-009 done  output  1  one-cycle pulse; result valid.
REQ-010 sum  output  WIDTH  (a+b) mod 2^WIDTH.
REQ-011 cout  output  1  carry out of bit WIDTH-1.

Function
REQ-012 FSM states SHALL be IDLE, ADD and DONE, with no other reachable states.
REQ-013 In IDLE with start=1 at a rising edge, the block SHALL capture a and b into shift registers, clear the carry flop and the bit counter, and go to ADD.
REQ-014 In IDLE with start=0, the state and all outputs SHALL hold.
REQ-015 In ADD, each cycle SHALL add one bit, LSB first: bit = a0 XOR b0 XOR c, and c_next = majority(a0, b0, c), i.e. two half-adder stages plus an OR.
REQ-016 In ADD, each cycle SHALL shift the operand registers right by one and shift the computed bit into the sum register at the MSB, so sum is LSB-aligned after WIDTH shifts.
REQ-017 The counter SHALL be $clog2(WIDTH+1) bits wide and SHALL increment once per ADD cycle.
REQ-018 After exactly WIDTH ADD cycles, the FSM SHALL go to DONE, with cout equal to the final carry.
REQ-019 In DONE, done SHALL be 1 for exactly one cycle, then the FSM SHALL go to IDLE unconditionally.
REQ-020 Latency: if start is accepted at edge k, done SHALL be high in the cycle following edge k+WIDTH.
REQ-021 sum and cout SHALL be valid while done=1 and SHALL hold stable in IDLE until the next start is accepted.
REQ-022 sum and cout are undefined while in ADD.
REQ-023 busy SHALL be 1 in ADD and DONE and 0 in IDLE; busy is registered, with no combinational path from start.
REQ-024 start SHALL be ignored in ADD and DONE, and changes on a and b during ADD SHALL NOT affect the result.
REQ-025 Back-to-back operation: start held high continuously SHALL produce one addition every WIDTH+2 cycles.
REQ-026 Overflow SHALL wrap modulo 2^WIDTH, with the lost bit reported only on cout.

Reset
REQ-027 While rst_n=0, the block SHALL be in state IDLE, with sum=0, cout=0, done=0, busy=0, and the counter, carry and operand registers all 0.
REQ-028 Reset asserted mid-operation SHALL abort the addition immediately, with no done pulse.
REQ-029 After rst_n rises, the block SHALL accept start on the first rising edge.
REQ-030 Reset deassertion SHALL NOT generate a done pulse or a spurious operation.

Verification (WIDTH=8)
REQ-031 Test a=0x00, b=0x00, start pulse -> done 8 cycles after the accepting edge, sum=0x00, cout=0.
REQ-032 Test a=0xFF, b=0x01 -> sum=0x00, cout=1; test a=0xFF, b=0xFF -> sum=0xFE, cout=1.
REQ-033 Test a=0xA5, b=0x5A -> sum=0xFF, cout=0, with busy high for exactly 9 cycles.
REQ-034 Pulse start again 3 cycles into an operation with different operands -> the pulse is ignored, the first result is unchanged, and there is one done pulse only.
REQ-035 Assert rst_n=0 in ADD cycle 4, then release and add 0x12 + 0x34 -> no done from the aborted operation, then sum=0x46, cout=0.
REQ-036 Run 256 random pairs with start held high -> each result matches a+b, done pulses are spaced by 10 cycles, and sum is stable between done pulses.
